// File: rtl/placar_pkg.sv
// Shared scoreboard types and constants: FSM states, operation/team encodings, score limits.
package placar_pkg;

    localparam int unsigned SCORE_W           = 7;
    localparam int unsigned PTS_W             = 2;
    localparam int unsigned SUM_W             = 8;
    localparam int unsigned DEFAULT_MAX_SCORE = 99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        UPDATE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic TEAM_A = 1'b0;
    localparam logic TEAM_B = 1'b1;

endpackage

// File: rtl/comparador.sv
// Subtraction guard: r is high when n2 >= n1, i.e. n2 - n1 stays non-negative.
module comparador
    import placar_pkg::*;
(
    input  logic [SCORE_W-1:0] n1,
    input  logic [SCORE_W-1:0] n2,
    output logic               r
);

    assign r = (n2 >= n1);

endmodule

// File: rtl/score_controller.sv
// Round-robin sequencer for team A/B score updates: grant, check, update, release.
module score_controller
    import placar_pkg::*;
#(
    parameter int unsigned MAX_SCORE = DEFAULT_MAX_SCORE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               req_a,
    input  logic               op_a,
    input  logic [PTS_W-1:0]   pts_a,
    input  logic               req_b,
    input  logic               op_b,
    input  logic [PTS_W-1:0]   pts_b,
    output logic               done_a,
    output logic               done_b,
    output logic               err_a,
    output logic               err_b,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               busy
);

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 op_q, op_d;
    logic [PTS_W-1:0]     pts_q, pts_d;
    logic                 ok_q, ok_d;
    logic                 last_grant_q, last_grant_d;
    logic [SCORE_W-1:0]   score_a_q, score_a_d;
    logic [SCORE_W-1:0]   score_b_q, score_b_d;
    logic                 done_a_q, done_a_d, done_b_q, done_b_d;
    logic                 err_a_q, err_a_d, err_b_q, err_b_d;
    logic                 busy_q, busy_d;

    logic                 grant_a_c;
    logic [SCORE_W-1:0]   sel_score_c;
    logic [SUM_W-1:0]     sum_c;
    logic                 add_ok_c;
    logic                 sub_ok_c;
    logic [SCORE_W-1:0]   new_score_c;

    assign sel_score_c = (sel_q == TEAM_A) ? score_a_q : score_b_q;

    comparador u_comparador (
        .n1 (SCORE_W'(pts_q)),
        .n2 (sel_score_c),
        .r  (sub_ok_c)
    );

    // 8-bit sum so 99 + 3 cannot wrap back into the legal range
    assign sum_c       = SUM_W'(sel_score_c) + SUM_W'(pts_q);
    assign add_ok_c    = (sum_c <= SUM_W'(MAX_SCORE));
    assign new_score_c = (op_q == OP_ADD) ? SCORE_W'(sum_c)
                                          : (sel_score_c - SCORE_W'(pts_q));

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        op_d         = op_q;
        pts_d        = pts_q;
        ok_d         = ok_q;
        last_grant_d = last_grant_q;
        score_a_d    = score_a_q;
        score_b_d    = score_b_q;
        done_a_d     = 1'b0;
        done_b_d     = 1'b0;
        err_a_d      = 1'b0;
        err_b_d      = 1'b0;
        grant_a_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    grant_a_c = req_a && (!req_b || (last_grant_q == TEAM_B));
                    sel_d     = grant_a_c ? TEAM_A : TEAM_B;
                    op_d      = grant_a_c ? op_a : op_b;
                    pts_d     = grant_a_c ? pts_a : pts_b;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                ok_d    = (pts_q != '0) && ((op_q == OP_SUB) ? sub_ok_c : add_ok_c);
                state_d = UPDATE;
            end
            UPDATE: begin
                if (ok_q) begin
                    if (sel_q == TEAM_A) begin
                        score_a_d = new_score_c;
                        done_a_d  = 1'b1;
                    end else begin
                        score_b_d = new_score_c;
                        done_b_d  = 1'b1;
                    end
                end else begin
                    err_a_d = (sel_q == TEAM_A);
                    err_b_d = (sel_q == TEAM_B);
                end
                last_grant_d = sel_q;
                state_d      = RELEASE;
            end
            RELEASE: begin
                // Hold until the granted requester lets go so one request applies once
                if (!((sel_q == TEAM_A) ? req_a : req_b)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides everything and drops any in-flight transaction silently
        if (clear) begin
            sel_d        = sel_q;
            op_d         = op_q;
            pts_d        = pts_q;
            ok_d         = ok_q;
            last_grant_d = last_grant_q;
            score_a_d    = '0;
            score_b_d    = '0;
            done_a_d     = 1'b0;
            done_b_d     = 1'b0;
            err_a_d      = 1'b0;
            err_b_d      = 1'b0;
            state_d      = (state_q == IDLE) ? IDLE : RELEASE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= TEAM_A;
            op_q         <= OP_ADD;
            pts_q        <= '0;
            ok_q         <= 1'b0;
            last_grant_q <= TEAM_B;
            score_a_q    <= '0;
            score_b_q    <= '0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            op_q         <= op_d;
            pts_q        <= pts_d;
            ok_q         <= ok_d;
            last_grant_q <= last_grant_d;
            score_a_q    <= score_a_d;
            score_b_q    <= score_b_d;
            done_a_q     <= done_a_d;
            done_b_q     <= done_b_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
            busy_q       <= busy_d;
        end
    end

    assign done_a  = done_a_q;
    assign done_b  = done_b_q;
    assign err_a   = err_a_q;
    assign err_b   = err_b_q;
    assign score_a = score_a_q;
    assign score_b = score_b_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: latency, guards, round-robin, clear and reset.
module tb_score_controller;
    import placar_pkg::*;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic       req_a, op_a, req_b, op_b;
    logic [1:0] pts_a, pts_b;
    logic       done_a, done_b, err_a, err_b, busy;
    logic [6:0] score_a, score_b;

    int n_cmp = 0;
    int n_err = 0;

    score_controller #(.MAX_SCORE(99)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .req_a(req_a), .op_a(op_a), .pts_a(pts_a),
        .req_b(req_b), .op_b(op_b), .pts_b(pts_b),
        .done_a(done_a), .done_b(done_b), .err_a(err_a), .err_b(err_b),
        .score_a(score_a), .score_b(score_b), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full request/response handshake; returns observations only
    task automatic run_txn(input logic team, input logic op, input logic [1:0] pts,
                           output int lat, output logic got_done, output logic got_err,
                           output logic other_pulse, output logic lingering, output int rel);
        @(negedge clk);
        if (team == TEAM_A) begin req_a = 1'b1; op_a = op; pts_a = pts; end
        else                begin req_b = 1'b1; op_b = op; pts_b = pts; end
        lat = 0; got_done = 1'b0; got_err = 1'b0; other_pulse = 1'b0;
        while (lat < 10 && !got_done && !got_err) begin
            tick();
            lat++;
            got_done = (team == TEAM_A) ? done_a : done_b;
            got_err  = (team == TEAM_A) ? err_a  : err_b;
            if ((team == TEAM_A) ? (done_b | err_b) : (done_a | err_a)) other_pulse = 1'b1;
            if ((team == TEAM_A) ? (done_a & err_a) : (done_b & err_b)) other_pulse = 1'b1;
        end
        if (team == TEAM_A) req_a = 1'b0; else req_b = 1'b0;
        tick();
        lingering = done_a | done_b | err_a | err_b;
        rel = 1;
        while (rel < 10 && busy) begin
            tick();
            rel++;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic load(input logic team, input int val);
        int v, lat, rel;
        logic d, e, o, l;
        v = val;
        while (v > 0) begin
            run_txn(team, OP_ADD, (v >= 3) ? 2'd3 : 2'(v), lat, d, e, o, l, rel);
            v -= (v >= 3) ? 3 : v;
        end
    endtask

    task automatic wait_pulse(output int cyc, output logic da, output logic ea,
                              output logic db, output logic eb);
        cyc = 0; da = 0; ea = 0; db = 0; eb = 0;
        while (cyc < 12 && !(da | ea | db | eb)) begin
            tick();
            cyc++;
            da = done_a; ea = err_a; db = done_b; eb = err_b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 0; req_a = 0; req_b = 0; op_a = 0; op_b = 0; pts_a = 0; pts_b = 0;
        tick(); tick();
        n_cmp++;
        if ({done_a, done_b, err_a, err_b, busy} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000", {done_a, done_b, err_a, err_b, busy});
        end
        n_cmp++;
        if (score_a !== 7'd0 || score_b !== 7'd0) begin
            n_err++; $display("FAIL reset_scores: got %0d/%0d want 0/0", score_a, score_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int lat, rel;
        logic d, e, o, l;
        run_txn(TEAM_A, OP_ADD, 2'd3, lat, d, e, o, l, rel);
        n_cmp++;
        if (lat !== 3 || d !== 1'b1 || e !== 1'b0) begin
            n_err++; $display("FAIL add_latency: got lat=%0d done=%b err=%b want lat=3 done=1 err=0", lat, d, e);
        end
        n_cmp++;
        if (score_a !== 7'd3 || score_b !== 7'd0) begin
            n_err++; $display("FAIL add_score: got %0d/%0d want 3/0", score_a, score_b);
        end
        n_cmp++;
        if (o !== 1'b0 || l !== 1'b0) begin
            n_err++; $display("FAIL add_pulse_shape: got other=%b lingering=%b want 0/0", o, l);
        end
        n_cmp++;
        if (rel !== 1) begin
            n_err++; $display("FAIL add_busy_drop: got %0d cycles want 1", rel);
        end
    endtask

    task automatic test_sub_guard();
        int lat, rel;
        logic d, e, o, l;
        load(TEAM_B, 1);
        run_txn(TEAM_B, OP_SUB, 2'd2, lat, d, e, o, l, rel);
        n_cmp++;
        if (d !== 1'b0 || e !== 1'b1 || score_b !== 7'd1) begin
            n_err++; $display("FAIL sub_under: got done=%b err=%b score=%0d want 0/1/1", d, e, score_b);
        end
        run_txn(TEAM_B, OP_SUB, 2'd1, lat, d, e, o, l, rel);
        n_cmp++;
        if (d !== 1'b1 || e !== 1'b0 || score_b !== 7'd0 || score_a !== 7'd3) begin
            n_err++; $display("FAIL sub_ok: got done=%b err=%b b=%0d a=%0d want 1/0/0/3", d, e, score_b, score_a);
        end
    endtask

    task automatic test_max();
        int lat, rel;
        logic d, e, o, l;
        do_clear();
        load(TEAM_A, 98);
        n_cmp++;
        if (score_a !== 7'd98) begin
            n_err++; $display("FAIL max_load: got %0d want 98", score_a);
        end
        run_txn(TEAM_A, OP_ADD, 2'd2, lat, d, e, o, l, rel);
        n_cmp++;
        if (d !== 1'b0 || e !== 1'b1 || score_a !== 7'd98) begin
            n_err++; $display("FAIL max_over: got done=%b err=%b score=%0d want 0/1/98", d, e, score_a);
        end
        run_txn(TEAM_A, OP_ADD, 2'd1, lat, d, e, o, l, rel);
        n_cmp++;
        if (d !== 1'b1 || e !== 1'b0 || score_a !== 7'd99) begin
            n_err++; $display("FAIL max_edge: got done=%b err=%b score=%0d want 1/0/99", d, e, score_a);
        end
    endtask

    task automatic test_zero_pts();
        int lat, rel;
        logic d, e, o, l;
        run_txn(TEAM_A, OP_ADD, 2'd0, lat, d, e, o, l, rel);
        n_cmp++;
        if (d !== 1'b0 || e !== 1'b1 || score_a !== 7'd99) begin
            n_err++; $display("FAIL zero_pts: got done=%b err=%b score=%0d want 0/1/99", d, e, score_a);
        end
    endtask

    task automatic test_round_robin();
        int lat, rel, cyc;
        logic d, e, o, l, da, ea, db, eb;
        // Make B the last grantee so A wins the first tie
        run_txn(TEAM_B, OP_ADD, 2'd1, lat, d, e, o, l, rel);
        do_clear();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            req_a = 1; op_a = OP_ADD; pts_a = 2'd1;
            req_b = 1; op_b = OP_ADD; pts_b = 2'd1;
            wait_pulse(cyc, da, ea, db, eb);
            n_cmp++;
            if ({da, ea, db, eb} !== 4'b1000 || cyc !== 3) begin
                n_err++; $display("FAIL rr_first_%0d: got pulses=%b cyc=%0d want 1000 cyc=3", r, {da, ea, db, eb}, cyc);
            end
            req_a = 0;
            wait_pulse(cyc, da, ea, db, eb);
            n_cmp++;
            if ({da, ea, db, eb} !== 4'b0010 || cyc !== 4) begin
                n_err++; $display("FAIL rr_second_%0d: got pulses=%b cyc=%0d want 0010 cyc=4", r, {da, ea, db, eb}, cyc);
            end
            req_b = 0;
            rel = 0;
            while (rel < 10 && busy) begin tick(); rel++; end
        end
        n_cmp++;
        if (score_a !== 7'd2 || score_b !== 7'd2 || busy !== 1'b0) begin
            n_err++; $display("FAIL rr_scores: got %0d/%0d busy=%b want 2/2/0", score_a, score_b, busy);
        end
        // Held request stays in RELEASE and is applied only once
        @(negedge clk);
        req_a = 1; op_a = OP_ADD; pts_a = 2'd1;
        wait_pulse(cyc, da, ea, db, eb);
        o = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_a | err_a | !busy) o = 1'b1;
        end
        n_cmp++;
        if (score_a !== 7'd3 || o !== 1'b0) begin
            n_err++; $display("FAIL held_once: got score=%0d extra=%b want 3/0", score_a, o);
        end
        req_a = 0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL held_release: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_clear();
        logic bad;
        do_clear();
        load(TEAM_A, 10);
        load(TEAM_B, 20);
        n_cmp++;
        if (score_a !== 7'd10 || score_b !== 7'd20) begin
            n_err++; $display("FAIL clear_setup: got %0d/%0d want 10/20", score_a, score_b);
        end
        @(negedge clk);
        req_b = 1; op_b = OP_ADD; pts_b = 2'd1;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (score_a !== 7'd0 || score_b !== 7'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL clear_scores: got %0d/%0d busy=%b want 0/0/1", score_a, score_b, busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_a | done_b | err_a | err_b | !busy) bad = 1'b1;
            tick();
        end
        req_b = 0;
        tick();
        n_cmp++;
        if (bad !== 1'b0 || busy !== 1'b0 || score_b !== 7'd0) begin
            n_err++; $display("FAIL clear_release: got bad=%b busy=%b b=%0d want 0/0/0", bad, busy, score_b);
        end
    endtask

    task automatic test_rst();
        int lat, rel;
        logic d, e, o, l;
        load(TEAM_A, 5);
        @(negedge clk);
        req_a = 1; op_a = OP_ADD; pts_a = 2'd1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({done_a, done_b, err_a, err_b, busy} !== 5'b0 || score_a !== 7'd0 || score_b !== 7'd0) begin
            n_err++; $display("FAIL rst_mid: got flags=%b a=%0d b=%0d want 00000/0/0",
                              {done_a, done_b, err_a, err_b, busy}, score_a, score_b);
        end
        tick();
        rst = 1'b0;
        req_a = 1'b0;
        tick();
        n_cmp++;
        if (done_a !== 1'b0 || score_a !== 7'd0) begin
            n_err++; $display("FAIL rst_no_pulse: got done=%b score=%0d want 0/0", done_a, score_a);
        end
        run_txn(TEAM_A, OP_ADD, 2'd2, lat, d, e, o, l, rel);
        n_cmp++;
        if (lat !== 3 || d !== 1'b1 || score_a !== 7'd2) begin
            n_err++; $display("FAIL rst_recover: got lat=%0d done=%b score=%0d want 3/1/2", lat, d, score_a);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_guard();
        test_max();
        test_zero_pts();
        test_round_robin();
        test_clear();
        test_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/score_controller.md
# score_controller

Sequences score updates for both teams of the basketball scoreboard. It accepts add/subtract requests (1–3 points) from the team A and team B input panels and arbitrates between them round-robin. Each subtraction is guarded by a `comparador` instance so a score never goes below zero, and additions are bounded at `MAX_SCORE`. It owns the two score registers that feed the display/BCD path.

## Interface
- `MAX_SCORE`, 99: highest legal score; an addition that would exceed it is rejected.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear of both scores; takes priority over all requests.
- `req_a`  in  1  team A request, held high until `done_a` or `err_a`, then dropped.
- `op_a`  in  1  team A operation: 0 = add, 1 = subtract; sampled at grant.
- `pts_a`  in  2  team A points, 1..3; sampled at grant.
- `req_b`, `op_b`, `pts_b`  in  1/1/2  team B equivalents.
- `done_a`, `done_b`  out  1  one-cycle pulse: update applied.
- `err_a`, `err_b`  out  1  one-cycle pulse: request rejected, score unchanged.
- `score_a`, `score_b`  out  7  current scores, 0..`MAX_SCORE`.
- `busy`  out  1  high in every state except IDLE.

## Operation
States:
- IDLE: if `req_a` or `req_b` is high, grant one requester. On a tie the grant goes to the team not granted last (`last_grant`). Latch `sel`, `op` and `pts`, then go to CHECK.
- CHECK: compute the verdict and register it into `ok`, then go to UPDATE.
  - Subtract: `ok` = comparador output R, with N2 = selected score and N1 = `pts`.
  - Add: `ok` = (score + `pts` <= `MAX_SCORE`). Compute in 8 bits, no wrap.
  - `pts` = 0 forces `ok` = 0 for either op.
- UPDATE:
  - If `ok`: write score ± `pts` and pulse `done_sel`.
  - Else: pulse `err_sel` and leave the score unchanged.
  - Update `last_grant` = `sel`, then go to RELEASE.
- RELEASE: wait for the granted `req` to be low, then go to IDLE. This prevents one held request from being applied twice. The other team's request stays pending and is not lost.

`clear`, in any state: both scores become 0 on the next edge. Any in-flight transaction is dropped without a done/err pulse. If a grant was held, the FSM goes to RELEASE; from IDLE it stays in IDLE, and no grant is issued in that cycle.

Reset values: state IDLE, `score_a` = `score_b` = 0, all done/err = 0, `busy` = 0, `last_grant` = B (so A wins the first tie).

## Timing
- Request sampled high in IDLE at edge k: grant at k, CHECK at k+1, score and done/err visible after edge k+2 (3-cycle latency from first high sample).
- done/err are exactly 1 cycle wide and mutually exclusive. At most one team is pulsed per transaction.
- Minimum spacing between two accepted transactions is 4 cycles: grant, CHECK, UPDATE, then RELEASE seeing the request low.
- `busy` rises the cycle after the grant edge and falls on entry to IDLE.
- Scores change only on UPDATE with `ok`, on `clear`, or on `rst`.
- `rst` mid-transaction: immediate return to reset values; no pulse is emitted.

## Structure
- Shared package `placar_pkg` holds:
  - state enum `{IDLE, CHECK, UPDATE, RELEASE}`;
  - `OP_ADD` = 1'b0, `OP_SUB` = 1'b1;
  - `TEAM_A` = 1'b0, `TEAM_B` = 1'b1;
  - the default `MAX_SCORE`.
- One sub-module instance: `comparador`, fed from the muxed selected score and the latched `pts`. It is the only subtraction guard; do not duplicate its logic.
- The arbiter is inline: a 1-bit `last_grant` and a priority mux.

## Test plan
- Reset, then A add 3 (`req_a` held until done) → `done_a` at 3rd cycle, `score_a` = 3, `score_b` = 0, `busy` back low after `req_a` drops.
- `score_b` = 1, B subtract 2 → `err_b`, `score_b` stays 1. Then B subtract 1 → `done_b`, `score_b` = 0.
- `score_a` = 98, A add 2 → `err_a`, score 98. Then A add 1 → `score_a` = 99.
- `req_a` and `req_b` rise together, both add 1, repeated twice → grant order A, B, A, B; each team's score +2. A request held high across RELEASE is applied once only.
- `pts_a` = 0 with add → `err_a`, no score change.
- Scores 10/20, `clear` asserted during CHECK of a B add → both scores 0, no `done_b`/`err_b`, FSM in RELEASE until `req_b` drops. Separately, `rst` asserted mid-UPDATE → all outputs at reset values.
